// File: rtl/seg7_counter_display.sv
// Binary-to-decimal display back-end: sequential double-dabble converter feeding a
// multiplexed common-anode 7-segment scanner. Define SEG7_LZ_BLANK_EN for leading-zero blanking.
module seg7_counter_display #(
    parameter int N           = 8,
    parameter int DIGITS      = 3,
    parameter int REFRESH_DIV = 1000
) (
    input  logic              i_clk,
    input  logic              r_reset,
    input  logic              i_ce,
    input  logic [N-1:0]      i_data,
    output logic [6:0]        o_seg,
    output logic [DIGITS-1:0] o_an,
    output logic              o_busy
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(N + 1);
    localparam int DW = $clog2(REFRESH_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [6:0]    SEG_DASH  = 7'b0111111;
    localparam logic [6:0]    SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [N-1:0]      bin_reg, bin_next;
    logic [BW-1:0]     bcd_reg, bcd_next;
    logic [BW-1:0]     bcd_adj;
    logic [CW-1:0]     bit_cnt_reg, bit_cnt_next;
    logic              ovf_reg, ovf_next;
    logic [BW-1:0]     disp_reg, disp_next;
    logic              dash_reg, dash_next;

    logic [DW-1:0]     div_reg, div_next;
    logic [IW-1:0]     idx_reg, idx_next;
    logic [6:0]        seg_reg, seg_next;
    logic [DIGITS-1:0] an_reg, an_next;

    logic [6:0]        digit_seg [DIGITS];
    logic [DIGITS-1:0] lz_blank;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

    // ---------------- converter FSM ----------------
    always_ff @(posedge i_clk or negedge r_reset) begin
        if (!r_reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (i_ce) state_next = ST_SHIFT;
            ST_SHIFT: if (bit_cnt_reg == LAST_BIT) state_next = ST_LATCH;
            ST_LATCH: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bin_next     = bin_reg;
        bcd_next     = bcd_reg;
        bit_cnt_next = bit_cnt_reg;
        ovf_next     = ovf_reg;
        disp_next    = disp_reg;
        dash_next    = dash_reg;
        case (state_reg)
            ST_IDLE: begin
                if (i_ce) begin
                    bin_next     = i_data;
                    bcd_next     = '0;
                    bit_cnt_next = '0;
                    ovf_next     = 1'b0;
                end
            end
            ST_SHIFT: begin
                // The bit leaving the top nibble is a lost thousands-and-up digit.
                {bcd_next, bin_next} = {bcd_adj[BW-2:0], bin_reg, 1'b0};
                bit_cnt_next         = bit_cnt_reg + CW'(1);
                ovf_next             = ovf_reg | bcd_adj[BW-1];
            end
            ST_LATCH: begin
                disp_next = bcd_reg;
                dash_next = ovf_reg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge r_reset) begin
        if (!r_reset) begin
            bin_reg     <= '0;
            bcd_reg     <= '0;
            bit_cnt_reg <= '0;
            ovf_reg     <= 1'b0;
            disp_reg    <= '0;
            dash_reg    <= 1'b0;
        end else begin
            bin_reg     <= bin_next;
            bcd_reg     <= bcd_next;
            bit_cnt_reg <= bit_cnt_next;
            ovf_reg     <= ovf_next;
            disp_reg    <= disp_next;
            dash_reg    <= dash_next;
        end
    end

    assign o_busy = (state_reg != ST_IDLE);

    // ---------------- per-digit correction and decode ----------------
`ifdef SEG7_LZ_BLANK_EN
    logic [DIGITS:0] upper_zero;
    assign upper_zero[DIGITS] = 1'b1;
`endif

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ? bcd_reg[4*gi +: 4] + 4'd3
                                                                 : bcd_reg[4*gi +: 4];
`ifdef SEG7_LZ_BLANK_EN
        // A digit is blank when it and every digit above it are zero; digit 0 always shows.
        assign upper_zero[gi] = upper_zero[gi+1] && (disp_reg[4*gi +: 4] == 4'd0);
        assign lz_blank[gi]   = (gi != 0) && upper_zero[gi];
`else
        assign lz_blank[gi]   = 1'b0;
`endif
        assign digit_seg[gi] = dash_reg     ? SEG_DASH  :
                               lz_blank[gi] ? SEG_BLANK :
                               seg_decode(disp_reg[4*gi +: 4]);
    end

    // ---------------- refresh scanner ----------------
    always_comb begin
        div_next = div_reg + DW'(1);
        idx_next = idx_reg;
        if (div_reg == DIV_LAST) begin
            div_next = '0;
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
        end
        seg_next = digit_seg[idx_reg];
        an_next  = ~(DIGITS'(1) << idx_reg);
    end

    always_ff @(posedge i_clk or negedge r_reset) begin
        if (!r_reset) begin
            div_reg <= '0;
            idx_reg <= '0;
            seg_reg <= SEG_BLANK;
            an_reg  <= '1;
        end else begin
            div_reg <= div_next;
            idx_reg <= idx_next;
            seg_reg <= seg_next;
            an_reg  <= an_next;
        end
    end

    assign o_seg = seg_reg;
    assign o_an  = an_reg;

endmodule

// File: tb/tb_seg7_counter_display.sv
// Scoreboard bench for seg7_counter_display: expected values are queued at stimulus time,
// a negedge monitor checks busy length, anode scan and decoded segments against a decimal model.
module tb_seg7_counter_display;

    localparam int N      = 10;
    localparam int DIGITS = 3;
    localparam int R      = 4;

    logic              clk     = 1'b0;
    logic              r_reset = 1'b1;
    logic              i_ce    = 1'b0;
    logic [N-1:0]      i_data  = '0;
    logic [6:0]        o_seg;
    logic [DIGITS-1:0] o_an;
    logic              o_busy;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int cur_exp   = 0;
    int win       = 0;
    int busy_cnt  = 0;
    bit prev_busy = 1'b0;
    int cyc       = 0;

    seg7_counter_display #(.N(N), .DIGITS(DIGITS), .REFRESH_DIV(R)) dut (
        .i_clk   (clk),
        .r_reset (r_reset),
        .i_ce    (i_ce),
        .i_data  (i_data),
        .o_seg   (o_seg),
        .o_an    (o_an),
        .o_busy  (o_busy)
    );

    always #5 clk = ~clk;

    // Edges since reset release.
    always @(posedge clk or negedge r_reset) begin
        if (!r_reset) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    function automatic logic [6:0] dec(input int digit);
        case (digit)
            0: dec = 7'b1000000;
            1: dec = 7'b1111001;
            2: dec = 7'b0100100;
            3: dec = 7'b0110000;
            4: dec = 7'b0011001;
            5: dec = 7'b0010010;
            6: dec = 7'b0000010;
            7: dec = 7'b1111000;
            8: dec = 7'b0000000;
            9: dec = 7'b0010000;
            default: dec = 7'b1111111;
        endcase
    endfunction

    function automatic int pow10(input int e);
        int p = 1;
        for (int k = 0; k < e; k++) p = p * 10;
        return p;
    endfunction

    // Segments that decimal value v should show on digit position d.
    function automatic logic [6:0] exp_seg(input int v, input int d);
        int p = pow10(d);
        if (v >= pow10(DIGITS)) return 7'b0111111;
`ifdef SEG7_LZ_BLANK_EN
        if (d > 0 && v < p) return 7'b1111111;
`endif
        return dec((v / p) % 10);
    endfunction

    initial begin : monitor
        int d;
        logic [DIGITS-1:0] ea;
        logic [6:0] es;
        forever begin
            @(negedge clk);
            if (!r_reset) begin
                checks++;
                if (o_seg !== 7'b1111111 || o_an !== {DIGITS{1'b1}} || o_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_outputs got seg=%b an=%b busy=%b required seg=1111111 an=%b busy=0",
                             o_seg, o_an, o_busy, {DIGITS{1'b1}});
                end
                win = N; cur_exp = 0; busy_cnt = 0; prev_busy = 1'b0;
            end else if (cyc > 0) begin
                d  = ((cyc - 1) / R) % DIGITS;
                ea = ~(DIGITS'(1) << d);
                checks++;
                if (o_an !== ea) begin
                    errors++;
                    $display("FAIL anode_scan cyc=%0d got=%b required=%b", cyc, o_an, ea);
                end
                if (win > 0) begin
                    es = exp_seg(cur_exp, d);
                    checks++;
                    if (o_seg !== es) begin
                        errors++;
                        $display("FAIL segments value=%0d digit=%0d got=%b required=%b", cur_exp, d, o_seg, es);
                    end else begin
                        $display("check value=%0d digit=%0d an=%b seg=%b ok", cur_exp, d, o_an, o_seg);
                    end
                    win--;
                end
                if (o_busy) begin
                    busy_cnt++;
                end else if (prev_busy) begin
                    checks++;
                    if (busy_cnt != N + 1) begin
                        errors++;
                        $display("FAIL busy_length got=%0d required=%0d", busy_cnt, N + 1);
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_conversion got=completion required=none");
                    end else begin
                        cur_exp = exp_q.pop_front();
                    end
                    win = N;
                    busy_cnt = 0;
                end
                prev_busy = o_busy;
            end
        end
    end

    task automatic wait_done();
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk); #1;
            if (exp_q.size() == 0 && win == 0) break;
        end
        if (k == 200) begin
            checks++;
            errors++;
            $display("FAIL timeout got=pending_%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic convert(input int v);
        @(negedge clk);
        i_data = N'(v); i_ce = 1'b1; exp_q.push_back(v);
        $display("issue value=%0d", v);
        @(negedge clk);
        i_ce = 1'b0;
        wait_done();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        #1 r_reset = 1'b0;
        repeat (3) @(posedge clk);
        #2 r_reset = 1'b1;
        wait_done();

        convert(47);
        convert(255);
        convert(0);
        convert(999);
        convert(1000);
        convert(1023);
        convert(100);

        // Input change during SHIFT is ignored; the held enable restarts with the new value.
        @(negedge clk);
        i_data = N'(5); i_ce = 1'b1; exp_q.push_back(5);
        $display("issue value=5 (back-to-back)");
        repeat (3) @(negedge clk);
        i_data = N'(9); exp_q.push_back(9);
        $display("issue value=9 (back-to-back)");
        repeat (N) @(negedge clk);
        i_ce = 1'b0;
        wait_done();

        // Reset four cycles into SHIFT aborts the conversion; the display must read 0 afterwards.
        @(negedge clk);
        i_data = N'(321); i_ce = 1'b1; exp_q.push_back(321);
        $display("issue value=321 (aborted by reset)");
        @(negedge clk);
        i_ce = 1'b0;
        repeat (4) @(posedge clk);
        #2 r_reset = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #2 r_reset = 1'b1;
        wait_done();
        convert(321);

        for (int i = 0; i < 20; i++) convert(int'($urandom_range(0, 1023)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
